// File: rtl/systolic_ctrl_4x4_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | systolic_ctrl_4x4_pkg : shared constants and FSM encoding for the  |
// |                         4x4 systolic array sequencer               |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package systolic_ctrl_4x4_pkg;

   localparam int SA_DIM        = 4;
   localparam int A_BUS_W       = 32;
   localparam int B_BUS_W       = 36;
   localparam int C_BUS_W       = 512;
   // Operand skew plus propagation until PE(3,3) has consumed its last pair
   localparam int FLUSH_CYC_DEF = 2 * (SA_DIM - 1);

   typedef logic [2:0] state_t;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_CLEAR  = 3'd1;
   localparam logic [2:0] ST_STREAM = 3'd2;
   localparam logic [2:0] ST_FLUSH  = 3'd3;
   localparam logic [2:0] ST_DONE   = 3'd4;

endpackage
`default_nettype wire

// File: rtl/systolic_ctrl_addr_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | systolic_ctrl_addr_gen : latched bases, k counter, read addressing |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module systolic_ctrl_addr_gen
   import systolic_ctrl_4x4_pkg::*;
#(
   parameter int KW = 8,
   parameter int AW = 9
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic [KW-1:0] cmd_k,
   input  logic [AW-1:0] cmd_a_base,
   input  logic [AW-1:0] cmd_b_base,
   input  logic          clear_phase,
   input  logic          stream_phase,
   output logic          rd_en,
   output logic [AW-1:0] a_addr,
   output logic [AW-1:0] b_addr,
   output logic          last,
   output logic          k_zero
);

   logic [KW-1:0] k_len_q, k_len_d;
   logic [KW-1:0] k_q, k_d;
   logic [AW-1:0] a_base_q, a_base_d;
   logic [AW-1:0] b_base_q, b_base_d;
   logic [AW-1:0] offset;

   always_comb begin
      k_len_d  = k_len_q;
      k_d      = k_q;
      a_base_d = a_base_q;
      b_base_d = b_base_q;
      if (load) begin
         k_len_d  = cmd_k;
         k_d      = '0;
         a_base_d = cmd_a_base;
         b_base_d = cmd_b_base;
      end else if (stream_phase) begin
         k_d = k_q + KW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         k_len_q  <= '0;
         k_q      <= '0;
         a_base_q <= '0;
         b_base_q <= '0;
      end else begin
         k_len_q  <= k_len_d;
         k_q      <= k_d;
         a_base_q <= a_base_d;
         b_base_q <= b_base_d;
      end
   end

   assign k_zero = (k_len_q == '0);
   assign last   = (k_q == k_len_q - KW'(1));

   // CLEAR prefetches word 0; STREAM at step k prefetches word k+1 (mod 2^AW)
   assign offset = clear_phase ? '0 : (AW'(k_q) + AW'(1));
   assign rd_en  = (clear_phase && !k_zero) || (stream_phase && !last);
   assign a_addr = rd_en ? (a_base_q + offset) : '0;
   assign b_addr = rd_en ? (b_base_q + offset) : '0;

endmodule
`default_nettype wire

// File: rtl/systolic_ctrl_4x4.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | systolic_ctrl_4x4 : command sequencer for the 4x4 systolic array;  |
// |                     SA_CTRL_PERF_EN adds perf_cycles/perf_cmds     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module systolic_ctrl_4x4
   import systolic_ctrl_4x4_pkg::*;
#(
   parameter int KW        = 8,
   parameter int AW        = 9,
   parameter int FLUSH_CYC = FLUSH_CYC_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [KW-1:0]      cmd_k,
   input  logic [AW-1:0]      cmd_a_base,
   input  logic [AW-1:0]      cmd_b_base,
   output logic               buf_a_rd_en,
   output logic [AW-1:0]      buf_a_addr,
   input  logic [A_BUS_W-1:0] buf_a_rdata,
   output logic               buf_b_rd_en,
   output logic [AW-1:0]      buf_b_addr,
   input  logic [B_BUS_W-1:0] buf_b_rdata,
   output logic               sa_start,
   output logic               sa_vld,
   output logic [A_BUS_W-1:0] sa_a_bus,
   output logic [B_BUS_W-1:0] sa_b_bus,
   input  logic [C_BUS_W-1:0] sa_c_bus,
   output logic               res_valid,
   input  logic               res_ready,
   output logic [C_BUS_W-1:0] res_data,
   output logic               busy
`ifdef SA_CTRL_PERF_EN
   ,
   output logic [31:0]        perf_cycles,
   output logic [15:0]        perf_cmds
`endif
);

   localparam int FCW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

   state_t         state_q, state_d;
   logic [FCW-1:0] flush_cnt_q, flush_cnt_d;
   logic           load;
   logic           clear_phase;
   logic           stream_phase;
   logic           rd_en;
   logic           last;
   logic           k_zero;
   logic [AW-1:0]  a_addr;
   logic [AW-1:0]  b_addr;

   systolic_ctrl_addr_gen #(
      .KW (KW),
      .AW (AW)
   ) u_addr_gen (
      .clk          (clk),
      .rst          (rst),
      .load         (load),
      .cmd_k        (cmd_k),
      .cmd_a_base   (cmd_a_base),
      .cmd_b_base   (cmd_b_base),
      .clear_phase  (clear_phase),
      .stream_phase (stream_phase),
      .rd_en        (rd_en),
      .a_addr       (a_addr),
      .b_addr       (b_addr),
      .last         (last),
      .k_zero       (k_zero)
   );

   always_comb begin
      state_d      = state_q;
      flush_cnt_d  = flush_cnt_q;
      cmd_ready    = 1'b0;
      sa_start     = 1'b0;
      sa_vld       = 1'b0;
      res_valid    = 1'b0;
      load         = 1'b0;
      clear_phase  = 1'b0;
      stream_phase = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               load    = 1'b1;
               state_d = ST_CLEAR;
            end
         end
         ST_CLEAR: begin
            sa_start    = 1'b1;
            clear_phase = 1'b1;
            // K=0 skips straight to DONE, presenting the freshly cleared array
            state_d     = k_zero ? ST_DONE : ST_STREAM;
         end
         ST_STREAM: begin
            sa_vld       = 1'b1;
            stream_phase = 1'b1;
            if (last) begin
               state_d     = ST_FLUSH;
               flush_cnt_d = '0;
            end
         end
         ST_FLUSH: begin
            sa_vld = 1'b1;
            if (flush_cnt_q == FCW'(FLUSH_CYC - 1)) begin
               state_d = ST_DONE;
            end else begin
               flush_cnt_d = flush_cnt_q + FCW'(1);
            end
         end
         ST_DONE: begin
            res_valid = 1'b1;
            if (res_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign buf_a_rd_en = rd_en;
   assign buf_b_rd_en = rd_en;
   assign buf_a_addr  = a_addr;
   assign buf_b_addr  = b_addr;
   assign sa_a_bus    = (state_q == ST_STREAM) ? buf_a_rdata : '0;
   assign sa_b_bus    = (state_q == ST_STREAM) ? buf_b_rdata : '0;
   assign res_data    = res_valid ? sa_c_bus : '0;
   assign busy        = (state_q != ST_IDLE);

`ifdef SA_CTRL_PERF_EN
   logic [31:0] perf_cycles_q, perf_cycles_d;
   logic [15:0] perf_cmds_q, perf_cmds_d;

   always_comb begin
      perf_cycles_d = perf_cycles_q;
      perf_cmds_d   = perf_cmds_q;
      if (busy && (perf_cycles_q != '1)) begin
         perf_cycles_d = perf_cycles_q + 32'd1;
      end
      if (res_valid && res_ready) begin
         perf_cmds_d = perf_cmds_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_cycles_q <= '0;
         perf_cmds_q   <= '0;
      end else begin
         perf_cycles_q <= perf_cycles_d;
         perf_cmds_q   <= perf_cmds_d;
      end
   end

   assign perf_cycles = perf_cycles_q;
   assign perf_cmds   = perf_cmds_q;
`else
   // Default build carries no performance counters.
`endif

endmodule
`default_nettype wire

// File: tb/tb_systolic_ctrl_4x4.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_systolic_ctrl_4x4 : bench with buffer/array models and a matmul |
// |                        reference; honours SA_CTRL_PERF_EN          |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_systolic_ctrl_4x4;

   localparam int FL = 6;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         cmd_valid = 1'b0;
   logic         cmd_ready;
   logic [7:0]   cmd_k = '0;
   logic [8:0]   cmd_a_base = '0;
   logic [8:0]   cmd_b_base = '0;
   logic         buf_a_rd_en, buf_b_rd_en;
   logic [8:0]   buf_a_addr, buf_b_addr;
   logic [31:0]  buf_a_rdata;
   logic [35:0]  buf_b_rdata;
   logic         sa_start, sa_vld;
   logic [31:0]  sa_a_bus;
   logic [35:0]  sa_b_bus;
   logic [511:0] sa_c_bus;
   logic         res_valid;
   logic         res_ready = 1'b0;
   logic [511:0] res_data;
   logic         busy;
`ifdef SA_CTRL_PERF_EN
   logic [31:0]  perf_cycles;
   logic [15:0]  perf_cmds;
`endif

   systolic_ctrl_4x4 dut (
      .clk         (clk),
      .rst         (rst),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_k       (cmd_k),
      .cmd_a_base  (cmd_a_base),
      .cmd_b_base  (cmd_b_base),
      .buf_a_rd_en (buf_a_rd_en),
      .buf_a_addr  (buf_a_addr),
      .buf_a_rdata (buf_a_rdata),
      .buf_b_rd_en (buf_b_rd_en),
      .buf_b_addr  (buf_b_addr),
      .buf_b_rdata (buf_b_rdata),
      .sa_start    (sa_start),
      .sa_vld      (sa_vld),
      .sa_a_bus    (sa_a_bus),
      .sa_b_bus    (sa_b_bus),
      .sa_c_bus    (sa_c_bus),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_data    (res_data),
      .busy        (busy)
`ifdef SA_CTRL_PERF_EN
      ,
      .perf_cycles (perf_cycles),
      .perf_cmds   (perf_cmds)
`endif
   );

   always #5 clk = ~clk;

   // Single-port buffers with one-cycle read latency
   logic [31:0] mem_a [512];
   logic [35:0] mem_b [512];

   always @(posedge clk) begin
      if (buf_a_rd_en) buf_a_rdata <= mem_a[buf_a_addr];
      if (buf_b_rd_en) buf_b_rdata <= mem_b[buf_b_addr];
   end

   // Functional array: clear on start, accumulate the outer product on vld
   logic signed [31:0] acc [4][4];

   always @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            if (sa_start) acc[i][j] <= 32'sd0;
            else if (sa_vld)
               acc[i][j] <= acc[i][j] + $signed(sa_a_bus[31-8*i -: 8]) * $signed(sa_b_bus[35-9*j -: 9]);
         end
      end
   end

   always_comb begin
      sa_c_bus = '0;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++)
            sa_c_bus[(i*4+j)*32 +: 32] = acc[i][j];
   end

   int n_checks = 0;
   int n_fail   = 0;

   int obs_start_cnt, obs_start_cyc, obs_vld_cnt, obs_vld_first, obs_res_cyc;
   int obs_leak, obs_unstable, obs_end_cyc;
   bit obs_timeout, obs_ready_after;
   logic [511:0] obs_res_data;
   int rd_a_q[$], rd_b_q[$], rd_cyc_q[$];

   function automatic logic [511:0] model_c(input int k, input int ab, input int bb);
      logic [511:0] r;
      logic [31:0]  aw;
      logic [35:0]  bw;
      int           s;
      r = '0;
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            s = 0;
            for (int t = 0; t < k; t++) begin
               aw = mem_a[(ab + t) % 512];
               bw = mem_b[(bb + t) % 512];
               s += int'($signed(aw[31-8*i -: 8])) * int'($signed(bw[35-9*j -: 9]));
            end
            r[(i*4+j)*32 +: 32] = s;
         end
      end
      return r;
   endfunction

   function automatic int exp_res_cyc(input int k);
      return (k == 0) ? 2 : k + FL + 2;
   endfunction

   task automatic fill_random();
      for (int i = 0; i < 512; i++) begin
         mem_a[i] = $urandom();
         mem_b[i] = {4'($urandom()), 32'($urandom())};
      end
   endtask

   // Issues one command and records what the DUT does, cycle 0 = accept cycle
   task automatic run_cmd(input int k, input int ab, input int bb, input int hold,
                          input bit keep, input int nk, input int nab, input int nbb);
      int c, w, limit;
      bit seen, done;
      obs_start_cnt = 0; obs_start_cyc = -1; obs_vld_cnt = 0; obs_vld_first = -1;
      obs_res_cyc = -1; obs_leak = 0; obs_unstable = 0; obs_res_data = '0;
      rd_a_q.delete(); rd_b_q.delete(); rd_cyc_q.delete();
      c = 0;
      while (cmd_ready !== 1'b1 && c < 40) begin @(posedge clk); #1; c++; end
      cmd_valid = 1'b1; cmd_k = 8'(k); cmd_a_base = 9'(ab); cmd_b_base = 9'(bb);
      c = 0; w = 0; seen = 0; done = 0; limit = k + hold + 40;
      while (!done && c < limit) begin
         if (sa_start) begin obs_start_cnt++; obs_start_cyc = c; end
         if (sa_vld) begin
            if (obs_vld_cnt == 0) obs_vld_first = c;
            obs_vld_cnt++;
         end
         if (buf_a_rd_en) begin rd_a_q.push_back(int'(buf_a_addr)); rd_cyc_q.push_back(c); end
         if (buf_b_rd_en) rd_b_q.push_back(int'(buf_b_addr));
         if ((c < 2 || c > k + 1) && (sa_a_bus !== '0 || sa_b_bus !== '0)) obs_leak++;
         if (!res_valid && res_data !== '0) obs_leak++;
         if (c > 0 && cmd_ready !== 1'b0) obs_leak++;
         if (busy !== (c > 0)) obs_leak++;
         if (res_valid) begin
            if (!seen) begin seen = 1; obs_res_cyc = c; obs_res_data = res_data; end
            else if (res_data !== obs_res_data) obs_unstable++;
            if (w == hold) res_ready = 1'b1;
            w++;
         end
         @(posedge clk); #1; c++;
         if (c == 1) begin
            if (keep) begin cmd_k = 8'(nk); cmd_a_base = 9'(nab); cmd_b_base = 9'(nbb); end
            else cmd_valid = 1'b0;
         end
         if (res_ready) begin res_ready = 1'b0; done = 1; end
      end
      obs_timeout = !done;
      obs_end_cyc = c;
      obs_ready_after = cmd_ready;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if ({sa_start, sa_vld, res_valid, buf_a_rd_en, buf_b_rd_en, busy} !== 6'b0) begin
         n_fail++; $display("FAIL reset_ctrl: got %b, expected 000000",
                            {sa_start, sa_vld, res_valid, buf_a_rd_en, buf_b_rd_en, busy});
      end
      n_checks++;
      if (buf_a_addr !== '0 || buf_b_addr !== '0 || sa_a_bus !== '0 || sa_b_bus !== '0 || res_data !== '0) begin
         n_fail++; $display("FAIL reset_data: addr %h/%h abus %h bbus %h, expected all zero",
                            buf_a_addr, buf_b_addr, sa_a_bus, sa_b_bus);
      end
      n_checks++;
      if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b, expected 1", cmd_ready); end
`ifdef SA_CTRL_PERF_EN
      n_checks++;
      if (perf_cycles !== 32'd0 || perf_cmds !== 16'd0) begin
         n_fail++; $display("FAIL reset_perf: got %0d/%0d, expected 0/0", perf_cycles, perf_cmds);
      end
`endif
      rst = 1'b0;
   endtask

   task automatic test_identity();
      logic [511:0] exp_m, exp_f;
      for (int t = 0; t < 4; t++) begin
         mem_a[t] = 32'h1 << (24 - 8 * t);
         mem_b[t] = {9'(t*4+1), 9'(t*4+2), 9'(t*4+3), 9'(t*4+4)};
      end
      exp_f = '0;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++)
            exp_f[(i*4+j)*32 +: 32] = 32'(i*4 + j + 1);
      exp_m = model_c(4, 0, 0);
      run_cmd(4, 0, 0, 0, 0, 0, 0, 0);
      n_checks++;
      if (obs_start_cnt != 1 || obs_start_cyc != 1) begin
         n_fail++; $display("FAIL ident_start: got %0d pulses at cycle %0d, expected 1 at 1", obs_start_cnt, obs_start_cyc);
      end
      n_checks++;
      if (obs_vld_first != 2 || obs_vld_cnt != 10) begin
         n_fail++; $display("FAIL ident_vld: got first %0d count %0d, expected 2/10", obs_vld_first, obs_vld_cnt);
      end
      n_checks++;
      if (obs_res_cyc != 12) begin n_fail++; $display("FAIL ident_res_cyc: got %0d, expected 12", obs_res_cyc); end
      n_checks++;
      if (obs_res_data !== exp_f) begin n_fail++; $display("FAIL ident_c_eq_b: got %h, expected %h", obs_res_data, exp_f); end
      n_checks++;
      if (obs_res_data !== exp_m) begin n_fail++; $display("FAIL ident_model: got %h, expected %h", obs_res_data, exp_m); end
      n_checks++;
      if (obs_leak != 0 || obs_timeout) begin
         n_fail++; $display("FAIL ident_protocol: got %0d violations timeout %0d, expected 0/0", obs_leak, obs_timeout);
      end
   endtask

   task automatic test_neg_one();
      int ab, bb;
      logic [511:0] exp_c;
      ab = $urandom_range(0, 511); bb = $urandom_range(0, 511);
      mem_a[ab] = 32'h02030405;
      mem_b[bb] = {4{9'h1FF}};
      exp_c = '0;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++)
            exp_c[(i*4+j)*32 +: 32] = -32'(i + 2);
      run_cmd(1, ab, bb, 1, 0, 0, 0, 0);
      n_checks++;
      if (obs_res_data !== exp_c) begin n_fail++; $display("FAIL neg_c: got %h, expected %h", obs_res_data, exp_c); end
      n_checks++;
      if (rd_cyc_q.size() != 1 || rd_b_q.size() != 1) begin
         n_fail++; $display("FAIL neg_read_cnt: got %0d/%0d reads, expected 1/1", rd_cyc_q.size(), rd_b_q.size());
      end else begin
         n_checks++;
         if (rd_cyc_q[0] != 1 || rd_a_q[0] != ab || rd_b_q[0] != bb) begin
            n_fail++; $display("FAIL neg_read: got cycle %0d addr %0d/%0d, expected 1 %0d/%0d",
                               rd_cyc_q[0], rd_a_q[0], rd_b_q[0], ab, bb);
         end
      end
      n_checks++;
      if (obs_res_cyc != 9 || obs_vld_cnt != 7) begin
         n_fail++; $display("FAIL neg_timing: got res %0d vld %0d, expected 9/7", obs_res_cyc, obs_vld_cnt);
      end
   endtask

   task automatic test_k_zero();
      fill_random();
      run_cmd(0, $urandom_range(0, 511), $urandom_range(0, 511), 2, 0, 0, 0, 0);
      n_checks++;
      if (rd_a_q.size() + rd_b_q.size() != 0) begin
         n_fail++; $display("FAIL k0_reads: got %0d reads, expected 0", rd_a_q.size() + rd_b_q.size());
      end
      n_checks++;
      if (obs_vld_cnt != 0 || obs_start_cnt != 1) begin
         n_fail++; $display("FAIL k0_ctrl: got vld %0d start %0d, expected 0/1", obs_vld_cnt, obs_start_cnt);
      end
      n_checks++;
      if (obs_res_cyc != 2) begin n_fail++; $display("FAIL k0_res_cyc: got %0d, expected 2", obs_res_cyc); end
      n_checks++;
      if (obs_res_data !== '0) begin n_fail++; $display("FAIL k0_data: got %h, expected 0", obs_res_data); end
   endtask

   task automatic test_wrap();
      int bb;
      logic [511:0] exp_c;
      int exp_a [4] = '{510, 511, 0, 1};
      fill_random();
      bb = $urandom_range(0, 511);
      exp_c = model_c(4, 510, bb);
      run_cmd(4, 510, bb, 0, 0, 0, 0, 0);
      n_checks++;
      if (rd_a_q.size() != 4 || rd_b_q.size() != 4) begin
         n_fail++; $display("FAIL wrap_cnt: got %0d/%0d reads, expected 4/4", rd_a_q.size(), rd_b_q.size());
      end else begin
         for (int t = 0; t < 4; t++) begin
            n_checks++;
            if (rd_a_q[t] != exp_a[t] || rd_b_q[t] != (bb + t) % 512) begin
               n_fail++; $display("FAIL wrap_addr%0d: got %0d/%0d, expected %0d/%0d",
                                  t, rd_a_q[t], rd_b_q[t], exp_a[t], (bb + t) % 512);
            end
         end
      end
      n_checks++;
      if (obs_res_data !== exp_c) begin n_fail++; $display("FAIL wrap_c: got %h, expected %h", obs_res_data, exp_c); end
   endtask

   task automatic test_back_to_back();
      int k1, k2, ab1, bb1, ab2, bb2;
      logic [511:0] exp1, exp2;
      fill_random();
      k1 = $urandom_range(1, 12); ab1 = $urandom_range(0, 511); bb1 = $urandom_range(0, 511);
      k2 = $urandom_range(1, 12); ab2 = $urandom_range(0, 511); bb2 = $urandom_range(0, 511);
      exp1 = model_c(k1, ab1, bb1);
      exp2 = model_c(k2, ab2, bb2);
      run_cmd(k1, ab1, bb1, 20, 1, k2, ab2, bb2);
      n_checks++;
      if (obs_res_data !== exp1) begin n_fail++; $display("FAIL b2b_c1: got %h, expected %h", obs_res_data, exp1); end
      n_checks++;
      if (obs_unstable != 0) begin n_fail++; $display("FAIL b2b_stable: got %0d changes, expected 0", obs_unstable); end
      n_checks++;
      if (obs_res_cyc != k1 + 8 || obs_end_cyc != k1 + 29) begin
         n_fail++; $display("FAIL b2b_timing1: got res %0d end %0d, expected %0d/%0d", obs_res_cyc, obs_end_cyc, k1 + 8, k1 + 29);
      end
      n_checks++;
      if (obs_ready_after !== 1'b1 || obs_leak != 0) begin
         n_fail++; $display("FAIL b2b_ready: got ready %b violations %0d, expected 1/0", obs_ready_after, obs_leak);
      end
      run_cmd(k2, ab2, bb2, 0, 0, 0, 0, 0);
      n_checks++;
      if (obs_start_cyc != 1 || obs_res_cyc != k2 + 8) begin
         n_fail++; $display("FAIL b2b_timing2: got start %0d res %0d, expected 1/%0d", obs_start_cyc, obs_res_cyc, k2 + 8);
      end
      n_checks++;
      if (obs_res_data !== exp2) begin n_fail++; $display("FAIL b2b_c2: got %h, expected %h", obs_res_data, exp2); end
   endtask

   task automatic test_reset_mid();
      int ab, bb;
      logic [511:0] exp_c;
      fill_random();
      cmd_valid = 1'b1; cmd_k = 8'd6; cmd_a_base = 9'($urandom()); cmd_b_base = 9'($urandom());
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if ({sa_start, sa_vld, res_valid, buf_a_rd_en, buf_b_rd_en, busy} !== 6'b0 || cmd_ready !== 1'b1) begin
         n_fail++; $display("FAIL mid_reset_ctrl: got %b ready %b, expected 000000 ready 1",
                            {sa_start, sa_vld, res_valid, buf_a_rd_en, buf_b_rd_en, busy}, cmd_ready);
      end
      n_checks++;
      if (buf_a_addr !== '0 || buf_b_addr !== '0 || sa_a_bus !== '0 || sa_b_bus !== '0 || res_data !== '0) begin
         n_fail++; $display("FAIL mid_reset_data: addr %h/%h abus %h bbus %h, expected all zero",
                            buf_a_addr, buf_b_addr, sa_a_bus, sa_b_bus);
      end
      rst = 1'b0;
      ab = $urandom_range(0, 511); bb = $urandom_range(0, 511);
      exp_c = model_c(3, ab, bb);
      run_cmd(3, ab, bb, 0, 0, 0, 0, 0);
      n_checks++;
      if (obs_res_data !== exp_c || obs_res_cyc != 11) begin
         n_fail++; $display("FAIL mid_fresh_c: got %h at %0d, expected %h at 11", obs_res_data, obs_res_cyc, exp_c);
      end
`ifdef SA_CTRL_PERF_EN
      n_checks++;
      if (perf_cmds !== 16'd1 || perf_cycles !== 32'd11) begin
         n_fail++; $display("FAIL mid_perf: got cmds %0d cycles %0d, expected 1/11", perf_cmds, perf_cycles);
      end
`endif
   endtask

   task automatic test_random();
      int k, ab, bb, bad;
      logic [511:0] exp_c;
      fill_random();
      for (int n = 0; n < 8; n++) begin
         k = $urandom_range(0, 24); ab = $urandom_range(0, 511); bb = $urandom_range(0, 511);
         exp_c = model_c(k, ab, bb);
         run_cmd(k, ab, bb, $urandom_range(0, 3), 0, 0, 0, 0);
         n_checks++;
         if (obs_res_data !== exp_c) begin n_fail++; $display("FAIL rnd%0d_c: got %h, expected %h", n, obs_res_data, exp_c); end
         n_checks++;
         if (obs_res_cyc != exp_res_cyc(k) || obs_timeout) begin
            n_fail++; $display("FAIL rnd%0d_res_cyc: got %0d, expected %0d", n, obs_res_cyc, exp_res_cyc(k));
         end
         bad = (rd_a_q.size() != k || rd_b_q.size() != k) ? 1 : 0;
         for (int t = 0; t < k && bad == 0; t++)
            if (rd_a_q[t] != (ab + t) % 512 || rd_b_q[t] != (bb + t) % 512 || rd_cyc_q[t] != t + 1) bad++;
         n_checks++;
         if (bad != 0 || obs_leak != 0) begin
            n_fail++; $display("FAIL rnd%0d_reads: got %0d reads, %0d violations, expected %0d reads, 0 violations",
                               n, rd_a_q.size(), obs_leak, k);
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_identity();
      test_neg_one();
      test_k_zero();
      test_wrap();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/systolic_ctrl_4x4.md
Name: systolic_ctrl_4x4

Overview:
Sequencer for the 4x4 output-stationary systolic array inside the TPU CFU. It accepts one matmul command: K and the base addresses of the A/B operand buffers. It then fetches K operand words from the two single-port buffers (1-cycle read latency) and drives the array's start/vld/a_bus/b_bus. It appends the drain cycles, then presents the 512-bit accumulator bus to the consumer with a valid/ready handshake.

Parameters:
KW, 8, width of the K-length field; K in 0..2^KW-1
AW, 9, operand buffer address width
FLUSH_CYC, 6, drain cycles after the last operand; equals 2*(4-1), the skew plus propagation to PE(3,3)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE
cmd_k  in  KW  inner dimension K
cmd_a_base  in  AW  A buffer base address
cmd_b_base  in  AW  B buffer base address
buf_a_rd_en  out  1  A buffer read enable
buf_a_addr  out  AW  A buffer read address
buf_a_rdata  in  32  {A[0,k],A[1,k],A[2,k],A[3,k]}, valid the cycle after rd_en
buf_b_rd_en  out  1  B buffer read enable
buf_b_addr  out  AW  B buffer read address
buf_b_rdata  in  36  {B[k,0..3]}, 9 bits each, valid the cycle after rd_en
sa_start  out  1  one-cycle accumulator clear to the array
sa_vld  out  1  array advance enable
sa_a_bus  out  32  A operand bus to the array
sa_b_bus  out  36  B operand bus to the array
sa_c_bus  in  512  array accumulators, row-major {row3..row0}
res_valid  out  1  result available
res_ready  in  1  consumer accepts the result
res_data  out  512  equals sa_c_bus while res_valid; 0 otherwise
busy  out  1  state != IDLE

Behaviour:
- Reset is synchronous, active-high, clk domain only. All outputs are 0 after reset; state is IDLE.
- A reset asserted mid-operation aborts the command. The array is left uncleared; the next command's CLEAR clears it.
- FSM states: IDLE, CLEAR, STREAM, FLUSH, DONE.
- IDLE: cmd_ready=1. On cmd_valid, latch K and both base addresses, then go to CLEAR.
- CLEAR (1 cycle):
  - sa_start=1, sa_vld=0.
  - If K>0: rd_en=1 on both buffers, addr = base+0; next state STREAM.
  - If K=0: no reads; next state DONE, so the result is all zeros.
- STREAM (K cycles, counter k=0..K-1):
  - sa_vld=1; sa_a_bus=buf_a_rdata; sa_b_bus=buf_b_rdata.
  - Issue read base+k+1 only while k+1<K.
  - After k=K-1, go to FLUSH.
- FLUSH (FLUSH_CYC cycles): sa_vld=1, buses forced to 0, no reads; then go to DONE.
- DONE:
  - res_valid=1, sa_vld=0, sa_start=0, so the accumulators hold and res_data stays stable.
  - Stay in DONE until res_ready; on the handshake go to IDLE.
  - No same-cycle bypass: a new command is accepted at the earliest one cycle after the result handshake.
- sa_a_bus and sa_b_bus are 0 in every state except STREAM.
- Address arithmetic is modulo 2^AW: base+k wraps past the top of the buffer.
- Latency: with the command accepted in cycle 0, res_valid rises in cycle K+FLUSH_CYC+2 (cycle 8+K with defaults).
- cmd_* inputs are ignored outside IDLE.

Optional Feature:
SA_CTRL_PERF_EN
- Defined: adds output perf_cycles (32). Free-running count of busy cycles, saturating at 2^32-1, cleared only by rst. Adds output perf_cmds (16), counting result handshakes, wrapping.
- Undefined: neither port nor its counters exist; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - FSM state encoding: IDLE=0, CLEAR=1, STREAM=2, FLUSH=3, DONE=4.
  - SA_DIM=4, A_BUS_W=32, B_BUS_W=36, C_BUS_W=512.
  - FLUSH_CYC derivation 2*(SA_DIM-1).
- One natural sub-module, systolic_ctrl_addr_gen: holds the latched base addresses and the k counter, and produces addr/rd_en/last. The FSM stays in the top.

Test Plan:
- K=4, A=identity rows, B[k,j]=k*4+j+1, bases 0/0 -> cycle-accurate start pulse at cycle 1; vld high cycles 2..11; res_valid at cycle 12; C equals B.
- K=1, A word 0x02030405, B all 9'h1FF (-1) -> C[i][j] = -A[i]: -2,-3,-4,-5; reads issued only in CLEAR.
- K=0 -> no buffer reads, vld never asserted, res_valid at cycle 2 with res_data all zero.
- a_base=2^AW-2, K=4 -> addresses 510,511,0,1 observed; C matches the model.
- res_ready held low 20 cycles then pulsed, with cmd_valid held high throughout -> res_data stable; cmd_ready rises the cycle after the handshake; second command completes correctly.
- rst asserted in STREAM k=2 -> next cycle all outputs 0, state IDLE. A following K=3 command produces a fresh, correct C. With SA_CTRL_PERF_EN defined, perf_cmds=1 after that command.
